// File: rtl/dshot_pwm_output_if.sv
// Decoded DShot frame bus: one frame per frame_done strobe from the input decoder.
interface dshot_pwm_output_if;
    logic        frame_done;
    logic [10:0] set_speed;
    logic [5:0]  special_command;
    logic        is_special_command;
    logic        crc_valid;

    modport master (
        output frame_done, set_speed, special_command, is_special_command, crc_valid
    );
    modport slave (
        input frame_done, set_speed, special_command, is_special_command, crc_valid
    );
endinterface

// File: rtl/dshot_pwm_output.sv
// Turns decoded DShot frames into a glitch-free ESC/servo PWM output.
// It also handles arming, the frame-loss watchdog and CRC-error accounting.
module dshot_pwm_output #(
    parameter int PERIOD_CYCLES    = 40000,
    parameter int MIN_PULSE_CYCLES = 16000,
    parameter int SCALE_SHIFT      = 3,
    parameter int MAX_SPEED        = 1999,
    parameter int ARM_FRAMES       = 10,
    parameter int FAILSAFE_CYCLES  = 1600000
) (
    input  logic               clk,
    input  logic               reset,
    dshot_pwm_output_if.slave  frame,
    output logic               pwm_out,
    output logic               armed,
    output logic               failsafe,
    output logic [7:0]         crc_err_count
);
    localparam int PW  = 16;
    localparam int WDW = $clog2(FAILSAFE_CYCLES);
    localparam int ACW = $clog2(ARM_FRAMES + 1);

    localparam logic [PW-1:0]  MIN_PULSE  = PW'(MIN_PULSE_CYCLES);
    localparam logic [PW-1:0]  LAST_COUNT = PW'(PERIOD_CYCLES - 1);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(FAILSAFE_CYCLES - 1);
    localparam logic [ACW-1:0] ARM_LAST   = ACW'(ARM_FRAMES - 1);
    localparam logic [ACW-1:0] ARM_FULL   = ACW'(ARM_FRAMES);

    // A full-throttle pulse must still leave a low phase every period.
    if (MIN_PULSE_CYCLES + (MAX_SPEED << SCALE_SHIFT) >= PERIOD_CYCLES) begin : g_pulse_range_check
        $error("dshot_pwm_output: maximum pulse does not fit inside the PWM period");
    end
    if (PERIOD_CYCLES > (1 << PW)) begin : g_period_range_check
        $error("dshot_pwm_output: PERIOD_CYCLES exceeds the 16-bit counter");
    end

    logic [PW-1:0]  target_pulse;
    logic [PW-1:0]  active_pulse;
    logic [PW-1:0]  period_count;
    logic [WDW-1:0] watchdog;
    logic [ACW-1:0] arm_count;
    logic           valid_frame;
    logic           wd_expire;

    function automatic logic [PW-1:0] throttle_pulse(input logic [10:0] speed);
        logic [10:0] clamped;
        clamped = (speed > 11'(MAX_SPEED)) ? 11'(MAX_SPEED) : speed;
        return MIN_PULSE + (PW'(clamped) << SCALE_SHIFT);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    assign valid_frame = frame.frame_done & frame.crc_valid;
    // A valid frame landing on the expiry cycle wins over the timeout.
    assign wd_expire   = ~failsafe & (watchdog == WD_LAST) & ~valid_frame;

    // Frame acceptance, arming and watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            armed         <= 1'b0;
            failsafe      <= 1'b0;
            crc_err_count <= 8'd0;
            arm_count     <= '0;
            watchdog      <= '0;
            target_pulse  <= MIN_PULSE;
        end else begin
            if (frame.frame_done && !frame.crc_valid) begin
                crc_err_count <= sat_inc8(crc_err_count);
            end
            if (valid_frame) begin
                watchdog <= '0;
                failsafe <= 1'b0;
                if (frame.is_special_command) begin
                    if (frame.special_command == 6'd0) begin
                        target_pulse <= MIN_PULSE;
                        if (!armed) begin
                            if (arm_count == ARM_LAST) begin
                                armed     <= 1'b1;
                                arm_count <= ARM_FULL;
                            end else begin
                                arm_count <= arm_count + 1'b1;
                            end
                        end
                    end else if (!armed) begin
                        arm_count <= '0;
                    end
                end else if (armed) begin
                    target_pulse <= throttle_pulse(frame.set_speed);
                end else begin
                    target_pulse <= MIN_PULSE;
                    arm_count    <= '0;
                end
            end else if (wd_expire) begin
                failsafe     <= 1'b1;
                armed        <= 1'b0;
                arm_count    <= '0;
                target_pulse <= MIN_PULSE;
            end else if (!failsafe) begin
                watchdog <= watchdog + 1'b1;
            end
        end
    end

    // PWM generator: the pulse width is only reloaded at the period boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            period_count <= '0;
            active_pulse <= MIN_PULSE;
            pwm_out      <= 1'b0;
        end else begin
            pwm_out <= (period_count < active_pulse);
            if (period_count == LAST_COUNT) begin
                period_count <= '0;
                active_pulse <= failsafe ? MIN_PULSE : target_pulse;
            end else begin
                period_count <= period_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dshot_pwm_output.sv
// Directed bench for dshot_pwm_output with shortened period, watchdog and speed range.
module tb_dshot_pwm_output;
    localparam int P    = 1000;
    localparam int MINP = 400;
    localparam int SH   = 1;
    localparam int MAXS = 199;
    localparam int ARM  = 10;
    localparam int FS   = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_out;
    logic       armed;
    logic       failsafe;
    logic [7:0] crc_err_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t_valid     = 0;

    dshot_pwm_output_if fb ();

    dshot_pwm_output #(
        .PERIOD_CYCLES   (P),
        .MIN_PULSE_CYCLES(MINP),
        .SCALE_SHIFT     (SH),
        .MAX_SPEED       (MAXS),
        .ARM_FRAMES      (ARM),
        .FAILSAFE_CYCLES (FS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame        (fb),
        .pwm_out      (pwm_out),
        .armed        (armed),
        .failsafe     (failsafe),
        .crc_err_count(crc_err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the frame is sampled by the following posedge.
    task automatic send_frame(input logic sp, input logic [5:0] cmd,
                              input logic [10:0] spd, input logic ok);
        fb.is_special_command = sp;
        fb.special_command    = cmd;
        fb.set_speed          = spd;
        fb.crc_valid          = ok;
        fb.frame_done         = 1'b1;
        @(negedge clk);
        fb.frame_done = 1'b0;
        if (ok) t_valid = cyc;
    endtask

    task automatic send_cmd0(input int n);
        for (int k = 0; k < n; k++) send_frame(1'b1, 6'd0, 11'd0, 1'b1);
    endtask

    task automatic wait_fall();
        int n = 0;
        while (pwm_out !== 1'b1 && n < 2*P) begin @(negedge clk); n++; end
        while (pwm_out !== 1'b0 && n < 4*P) begin @(negedge clk); n++; end
        if (n >= 4*P) check("wait_fall_timeout", n, 0);
    endtask

    // Width of the next pulse that starts after a low phase; -1 on timeout.
    task automatic measure_next(output int w);
        int n = 0;
        w = 0;
        while (pwm_out !== 1'b0 && n < 2*P) begin @(negedge clk); n++; end
        while (pwm_out !== 1'b1 && n < 4*P) begin @(negedge clk); n++; end
        while (pwm_out === 1'b1 && w < 2*P) begin w++; @(negedge clk); end
        if (n >= 4*P) w = -1;
    endtask

    // Cycles from the last valid frame until failsafe rises; -1 on timeout.
    task automatic wait_failsafe(output int dt);
        int n = 0;
        while (failsafe !== 1'b1 && n < FS + 2*P) begin @(negedge clk); n++; end
        dt = (failsafe === 1'b1) ? (cyc - t_valid) : -1;
    endtask

    initial begin
        int w;
        int lo;
        int dt;

        fb.frame_done         = 1'b1;
        fb.crc_valid          = 1'b0;
        fb.is_special_command = 1'b0;
        fb.special_command    = 6'd0;
        fb.set_speed          = 11'd0;
        reset                 = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_pwm", pwm_out, 0);
        check("reset_armed", armed, 0);
        check("reset_failsafe", failsafe, 0);
        check("reset_crc_ignores_frames", crc_err_count, 0);
        fb.frame_done = 1'b0;
        reset         = 1'b0;

        // Idle after reset: minimum pulse, first high one cycle after release
        @(negedge clk);
        check("first_high", pwm_out, 1);
        w = 0;
        while (pwm_out === 1'b1 && w < 2*P) begin w++; @(negedge clk); end
        check("idle_high", w, MINP);
        lo = 0;
        while (pwm_out === 1'b0 && lo < 2*P) begin lo++; @(negedge clk); end
        check("idle_low", lo, P - MINP);
        check("idle_armed", armed, 0);
        check("idle_failsafe", failsafe, 0);

        // Throttle while disarmed is ignored
        wait_fall();
        send_frame(1'b0, 6'd0, 11'd100, 1'b1);
        measure_next(w);
        check("disarmed_throttle", w, MINP);
        check("disarmed_armed", armed, 0);

        // Nine command-0 frames then a throttle frame restarts arming
        wait_fall();
        send_cmd0(9);
        check("arm_9_frames", armed, 0);
        send_frame(1'b0, 6'd0, 11'd100, 1'b1);
        measure_next(w);
        check("arm_broken_pulse", w, MINP);
        check("arm_broken_armed", armed, 0);
        wait_fall();
        send_cmd0(9);
        check("rearm_9_frames", armed, 0);
        send_cmd0(1);
        check("rearm_10th_frame", armed, 1);

        // Armed throttle scaling and clamp
        send_frame(1'b0, 6'd0, 11'd100, 1'b1);
        measure_next(w);
        check("throttle_100", w, MINP + (100 << SH));
        wait_fall();
        send_frame(1'b0, 6'd0, 11'd199, 1'b1);
        measure_next(w);
        check("throttle_max", w, MINP + (MAXS << SH));
        wait_fall();
        send_frame(1'b1, 6'd5, 11'd0, 1'b1);
        measure_next(w);
        check("cmd5_keeps_target", w, MINP + (MAXS << SH));
        check("cmd5_armed", armed, 1);
        wait_fall();
        send_frame(1'b0, 6'd0, 11'd2047, 1'b1);
        measure_next(w);
        check("throttle_clamp", w, MINP + (MAXS << SH));

        // Mid-period target change leaves the running pulse alone
        wait_fall();
        send_frame(1'b0, 6'd0, 11'd50, 1'b1);
        measure_next(w);
        check("throttle_50", w, MINP + (50 << SH));
        lo = 0;
        while (pwm_out !== 1'b1 && lo < 2*P) begin @(negedge clk); lo++; end
        w = 0;
        while (pwm_out === 1'b1 && w < 2*P) begin
            w++;
            if (w == 100) begin
                fb.is_special_command = 1'b0;
                fb.set_speed          = 11'd150;
                fb.crc_valid          = 1'b1;
                fb.frame_done         = 1'b1;
            end else begin
                fb.frame_done = 1'b0;
            end
            @(negedge clk);
            if (w == 100) t_valid = cyc;
        end
        fb.frame_done = 1'b0;
        check("midperiod_current", w, MINP + (50 << SH));
        measure_next(w);
        check("midperiod_next", w, MINP + (150 << SH));

        // Bad-CRC frames: counted, saturating, no effect on target or watchdog
        wait_fall();
        send_frame(1'b0, 6'd0, 11'd150, 1'b1);
        for (int k = 0; k < 3; k++) send_frame(1'b0, 6'd0, 11'd0, 1'b0);
        check("crc_count_3", crc_err_count, 3);
        for (int k = 0; k < 297; k++) send_frame(1'b0, 6'd0, 11'd0, 1'b0);
        check("crc_count_sat", crc_err_count, 255);
        measure_next(w);
        check("crc_pulse_kept", w, MINP + (150 << SH));
        check("crc_armed_kept", armed, 1);
        wait_failsafe(dt);
        check("failsafe_delay", dt, FS);
        check("failsafe_disarms", armed, 0);
        measure_next(w);
        check("failsafe_pulse", w, MINP);

        // One valid frame clears failsafe; re-arming needs ARM fresh frames
        send_frame(1'b0, 6'd0, 11'd100, 1'b1);
        check("failsafe_cleared", failsafe, 0);
        check("failsafe_still_disarmed", armed, 0);
        measure_next(w);
        check("post_failsafe_pulse", w, MINP);
        send_cmd0(9);
        check("post_fs_9_frames", armed, 0);
        send_cmd0(1);
        check("post_fs_10th_frame", armed, 1);

        // Valid frame on the expiry cycle beats the timeout
        for (int k = 0; k < FS && (cyc - t_valid) < FS - 1; k++) @(negedge clk);
        check("pre_expiry_failsafe", failsafe, 0);
        send_frame(1'b1, 6'd0, 11'd0, 1'b1);
        check("coincide_failsafe", failsafe, 0);
        check("coincide_armed", armed, 1);
        wait_failsafe(dt);
        check("coincide_restart_delay", dt, FS);

        // Reset in the middle of a pulse
        send_frame(1'b1, 6'd0, 11'd0, 1'b1);
        wait_fall();
        lo = 0;
        while (pwm_out !== 1'b1 && lo < 2*P) begin @(negedge clk); lo++; end
        repeat (50) @(negedge clk);
        check("pre_reset_high", pwm_out, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_midpulse_pwm", pwm_out, 0);
        check("reset_midpulse_crc", crc_err_count, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dshot_pwm_output.md
Name: dshot_pwm_output

Overview:
- Downstream consumer of the DShot input decoder. Takes each decoded frame (speed, special command, CRC flag) and drives a standard ESC/servo PWM output, nominally 400 Hz with 1000–2000 µs pulses.
- Owns the arming sequence, the failsafe watchdog, and CRC-error accounting.
- Pulse width changes only at PWM period boundaries, so pwm_out is glitch-free.

Parameters:
- PERIOD_CYCLES, 40000: PWM period in clk cycles (2.5 ms at 16 MHz).
- MIN_PULSE_CYCLES, 16000: pulse width for zero throttle (1000 µs).
- SCALE_SHIFT, 3: pulse = MIN_PULSE_CYCLES + (speed << SCALE_SHIFT). Speed 1999 gives 31992 cycles.
- MAX_SPEED, 1999: throttle clamp value.
- ARM_FRAMES, 10: consecutive valid command-0 frames needed to arm.
- FAILSAFE_CYCLES, 1600000: frame-loss timeout (100 ms).

Ports:
- clk  in  1  system clock (16 MHz).
- reset  in  1  synchronous reset, active-high.
- frame_done  in  1  one-cycle strobe from the decoder. Frame fields are valid in this cycle.
- set_speed  in  11  decoded throttle, 0..1999 nominal.
- special_command  in  6  decoded command number.
- is_special_command  in  1  frame carries a command, not a throttle.
- crc_valid  in  1  frame checksum OK.
- pwm_out  out  1  registered PWM output.
- armed  out  1  throttle frames are honoured.
- failsafe  out  1  watchdog has expired.
- crc_err_count  out  8  saturating count of rejected frames.

Behaviour:
- Reset values:
  - pwm_out=0, armed=0, failsafe=0, crc_err_count=0.
  - Period counter=0, arm counter=0, watchdog=0.
  - target pulse = active pulse = MIN_PULSE_CYCLES.
- Frame acceptance, evaluated only in cycles where frame_done=1:
  - crc_valid=0: crc_err_count+1, saturating at 255. No other state changes. Watchdog not refreshed.
  - crc_valid=1, any type: watchdog cleared, failsafe cleared.
  - Valid, is_special_command=1, special_command=0: target=MIN_PULSE_CYCLES. If disarmed, arm counter +1. When the counter reaches ARM_FRAMES: armed=1 and counter held.
  - Valid, special_command 1..47: target unchanged. Arm counter cleared if disarmed. Watchdog still refreshed.
  - Valid throttle, armed=1: speed clamped to MAX_SPEED, then target = MIN + (speed << SCALE_SHIFT), computed in 16-bit arithmetic.
  - Valid throttle, armed=0: target stays MIN and arm counter is cleared.
  - Target register updates on the clock edge ending the frame_done cycle.
- Watchdog:
  - Increments every cycle while failsafe=0.
  - On reaching FAILSAFE_CYCLES-1 with no valid frame in that cycle: failsafe=1, armed=0, arm counter=0, target=MIN, watchdog stops.
  - If a valid frame and expiry coincide in the same cycle, the frame wins: no failsafe.
  - Leaving failsafe requires a valid frame, which clears failsafe. Re-arming requires ARM_FRAMES fresh command-0 frames.
- PWM generator:
  - Period counter runs 0..PERIOD_CYCLES-1 and wraps.
  - At count PERIOD_CYCLES-1, active pulse is loaded from target (or MIN if failsafe=1) for the next period.
  - pwm_out is registered as (count < active pulse), giving one cycle of latency from count.
  - After reset deasserts, the first high cycle appears one cycle later, with MIN width.
  - Target changes mid-period never alter the current pulse.
  - End-to-end latency: target visible from the next period start, at most PERIOD_CYCLES+2 cycles after frame_done.
- Boundaries:
  - A pulse equal to PERIOD_CYCLES is not reachable with the defaults. The implementation asserts that MIN + (MAX_SPEED << SCALE_SHIFT) < PERIOD_CYCLES.
  - frame_done asserted during reset is ignored.
  - Reset mid-pulse drives pwm_out low on the next edge.

Test Plan:
- Reset, then no frames for 40000 cycles: pwm_out high for exactly 16000 cycles per period. armed=0 and failsafe=0 for the first period.
- 10 valid command-0 frames, then throttle 1000: armed rises on the 10th frame. The next full period has a 24000-cycle pulse. Throttle 1999 gives 31992 cycles. An out-of-range input of 2047 is clamped to 31992.
- Throttle 1000 sent while disarmed, and 9 command-0 frames followed by a throttle frame: pulse stays 16000 and armed stays 0. Arming then requires 10 more command-0 frames.
- Armed at throttle 500, then frames stop for 1600000 cycles: failsafe=1, armed=0, pulse returns to 16000 from the next period. One valid frame clears failsafe; armed stays 0.
- 300 frames with crc_valid=0 while armed at throttle 800: pulse stays 22400. crc_err_count saturates at 255. Failsafe still trips after 1600000 cycles, because bad frames do not refresh the watchdog.
- Throttle change from 200 to 1500 issued at period count 10000: the current pulse stays 17600. The next period is 28000. Also check frame_done coinciding with watchdog expiry: failsafe stays 0.
